// File: rtl/alu_ctrl_md.sv
// RV32I ALU control decoder with an iterative shift-add / restoring-division M-extension engine.
// Build option: define ALU_MDIV_DIV_EN to include the divider; otherwise divide ops decode as illegal.
module alu_ctrl_md #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [6:0]      opcode,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      alu_control,
  output logic            is_md,
  output logic            stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic            illegal_op
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_MDIV_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_next, mul_next, prod_fix;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   opb_mag, mag_a, mag_b, fin_res;
  logic              res_neg, alt, neg_d, alt_d;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic              md_ok, start, busy;

  // ---------------- decode ----------------
  always_comb begin
    is_md       = (opcode == OPC_R) && (funct7 == F7_MD) && (alu_op == 2'b10);
    alu_control = ALU_ADD;
    illegal_op  = 1'b0;
    case (alu_op)
      2'b00: alu_control = ALU_ADD;
      2'b01: alu_control = ALU_SUB;
      2'b11: begin
        alu_control = ALU_AND;
        illegal_op  = 1'b1;
      end
      default: begin
        if (!is_md) begin
          case (funct3)
            3'b000:  alu_control = (opcode == OPC_R && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            default: alu_control = ALU_AND;
          endcase
        end
      end
    endcase
    if (opcode == OPC_R && funct7 != F7_BASE && funct7 != F7_ALT && funct7 != F7_MD)
      illegal_op = 1'b1;
`ifndef ALU_MDIV_DIV_EN
    if (is_md && funct3[2])
      illegal_op = 1'b1;
`endif
  end

`ifdef ALU_MDIV_DIV_EN
  assign md_ok = 1'b1;
`else
  assign md_ok = ~funct3[2];
`endif

  // Handshake: the pipeline holds inputs stable while stall=1; md_done marks a one-cycle valid md_result.
  assign stall   = in_valid & is_md & md_ok & (state != S_DONE);
  assign md_done = (state == S_DONE);
  assign start   = in_valid & is_md & md_ok & ~flush & (state == S_IDLE);

  // ---------------- operand preparation ----------------
  assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign sign_a   = a_signed & op_a[XLEN-1];
  assign sign_b   = b_signed & op_b[XLEN-1];
  assign mag_a    = sign_a ? -op_a : op_a;
  assign mag_b    = sign_b ? -op_b : op_b;
  // Remainder takes the dividend sign; products and quotients take sign_a^sign_b.
  assign neg_d    = (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
  assign alt_d    = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);

  // ---------------- iteration datapath ----------------
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_mag} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign prod_fix = res_neg ? -acc_next : acc_next;

`ifdef ALU_MDIV_DIV_EN
  logic [XLEN:0]   div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0] div_pick, spec_res;
  logic            div_zero, div_ovf, special;

  // acc holds {remainder, dividend/quotient}; the top XLEN+1 bits are the shifted partial remainder.
  assign div_shift = acc[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opb_mag};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
  assign acc_next  = (state == S_DIV) ? div_next : mul_next;
  assign div_pick  = alt ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
  assign busy      = (state == S_MUL) || (state == S_DIV);

  assign div_zero  = (op_b == '0);
  assign div_ovf   = ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
  assign special   = funct3[2] & (div_zero | div_ovf);
  assign spec_res  = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);

  always_comb begin
    fin_res = alt ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    if (state == S_DIV)
      fin_res = res_neg ? -div_pick : div_pick;
  end
`else
  assign acc_next = mul_next;
  assign busy     = (state == S_MUL);
  assign fin_res  = alt ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_MUL;
`ifdef ALU_MDIV_DIV_EN
        if (start && funct3[2]) state_d = special ? S_DONE : S_DIV;
`endif
      end
      S_MUL:   if (cnt == LAST) state_d = S_DONE;
`ifdef ALU_MDIV_DIV_EN
      S_DIV:   if (cnt == LAST) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      opb_mag   <= '0;
      res_neg   <= 1'b0;
      alt       <= 1'b0;
      md_result <= '0;
    end else if (!flush) begin
      if (start) begin
        cnt     <= '0;
        acc     <= {{XLEN{1'b0}}, mag_a};
        opb_mag <= mag_b;
        res_neg <= neg_d;
        alt     <= alt_d;
`ifdef ALU_MDIV_DIV_EN
        if (special) md_result <= spec_res;
`endif
      end else if (busy) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) md_result <= fin_res;
      end
    end
  end

endmodule

// File: doc/alu_ctrl_md.md
# alu_ctrl_md

Parametrised successor to the single-cycle ALU control decoder. Decodes the complete RV32I register/immediate ALU operation set into a 4-bit `alu_control` code for the single-cycle ALU. Adds an iterative multi-cycle multiply/divide engine for the M extension, which stalls the pipeline through a stall/done interface. Sits between the main control unit and the execute stage.

## Interface

**Parameters**
- `XLEN`, 32, operand and result width; must be ≥ 8 and a power of two.

**Ports**
- `clk`, input, 1, clock; all state changes on the rising edge.
- `rst_n`, input, 1, reset; asynchronous, active-low.
- `in_valid`, input, 1, decode inputs and operands are valid this cycle.
- `flush`, input, 1, abort any in-flight M operation.
- `opcode`, input, 7, instruction opcode.
- `funct7`, input, 7, instruction funct7.
- `funct3`, input, 3, instruction funct3.
- `alu_op`, input, 2, class from main control: 00 add, 01 sub, 10 R/I-type.
- `op_a`, input, XLEN, rs1 value.
- `op_b`, input, XLEN, rs2 value.
- `alu_control`, output, 4, single-cycle ALU code; combinational.
- `is_md`, output, 1, current instruction is an M-extension op; combinational.
- `stall`, output, 1, hold the pipeline; combinational.
- `md_done`, output, 1, `md_result` is valid this cycle.
- `md_result`, output, XLEN, M-op result; registered.
- `illegal_op`, output, 1, unsupported encoding; combinational.

## Operation

**`alu_control` codes**
- 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLTU, 0011 XOR, 0100 SLL, 0101 SRL, 1101 SRA.

**Decode**
- `alu_op`=00 gives ADD.
- `alu_op`=01 gives SUB.
- `alu_op`=11 gives 0000 and sets `illegal_op`.
- `alu_op`=10 decodes on funct3:
  - 000 gives SUB only when opcode=0110011 and funct7=0100000; otherwise ADD.
  - 101 gives SRA when funct7=0100000; otherwise SRL.
- R-type with funct7 outside {0000000, 0100000, 0000001} sets `illegal_op`.

**M ops**
- An M op is opcode=0110011, funct7=0000001, `alu_op`=10. It sets `is_md`, and `alu_control` is 0010.
- funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.

**State machine**
- States: IDLE, MUL, DIV, DONE.
- IDLE → MUL or DIV when `in_valid & is_md`:
  - Latch operand magnitudes and the result sign. Product/quotient sign is sign_a^sign_b; remainder sign is sign_a. MULHSU treats `op_b` as unsigned.
  - Clear the iteration counter.
- MUL: shift-add, one bit per cycle, 2·XLEN-bit accumulator, XLEN iterations, then → DONE.
- DIV: restoring division, one quotient bit per cycle, XLEN iterations, then → DONE.
- Going to DONE: apply two's-complement sign fixup and register `md_result`. MUL returns the low half; MULH* return the high half.
- DONE: `md_done`=1, then → IDLE.

**Special cases** (detected in IDLE; go straight to DONE)
- Divide by zero: quotient is all-ones; remainder is `op_a`.
- Signed overflow (most-negative ÷ −1): quotient is `op_a`; remainder is 0.

**Stall and flush**
- `stall` = `in_valid & is_md & (state != DONE)`.
- `flush` in any state → IDLE next cycle. `md_done` stays 0 and `md_result` is unchanged.

## Timing

**Reset** (asynchronous, while `rst_n`=0)
- State → IDLE.
- `md_done`=0, `md_result`=0, counter=0.
- Combinational outputs follow their inputs.
- Reset mid-operation discards the operation.

**Latency**
- Normal M op: accepted in cycle 0; `stall` is high for cycles 0..XLEN; `md_done` and `stall`=0 in cycle XLEN+1.
- Special case: `stall` is high in cycle 0 only; `md_done` in cycle 1.

**Back-to-back and simultaneous events**
- Back-to-back M ops: the second is accepted in the cycle after DONE.
- Non-M ops never stall and have zero latency.
- `flush` and DONE in the same cycle: `md_done` is still asserted that cycle, and the next state is IDLE.
- Inputs are held stable by the pipeline while `stall`=1. The engine ignores input changes after acceptance.

## Configuration

- `ALU_MDIV_DIV_EN` defined: DIV/DIVU/REM/REMU are executed as above.
- `ALU_MDIV_DIV_EN` undefined:
  - The DIV state and divider datapath are removed.
  - The four divide ops assert `illegal_op` and `is_md` with `stall`=0 and never start the engine.
  - `md_done` stays 0 for them.
  - Multiply ops are unaffected.

## Test plan

- Decode sweep: every RV32I R/I funct3/funct7 combination with `alu_op`=10, plus 00/01/11 → codes exactly as listed. ADDI with funct7=0100000 gives 0010.
- MUL, XLEN=32: `op_a`=0xFFFFFFFF (−1), `op_b`=7, funct3=000 → `stall` for 33 cycles; `md_done` at cycle 33; `md_result`=0xFFFFFFF9. The same operands with MULHU give 0x00000006.
- DIV: `op_a`=−20, `op_b`=3 → DIV=0xFFFFFFFA (−6); REM=0xFFFFFFFE (−2).
- Divide by zero: DIVU 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5. Overflow: DIV 0x80000000/−1 gives 0x80000000. Both complete with `md_done` at cycle 1.
- Flush and reset: `flush` at cycle 10 of a MUL → IDLE next cycle, no `md_done`, `md_result` unchanged. Deasserting `rst_n` mid-DIV → immediate IDLE and `md_result`=0.
- Build without `ALU_MDIV_DIV_EN`: DIV → `illegal_op`=1, `stall`=0, `md_done` never asserted. MUL still completes in 33 cycles.
